// File: rtl/serial_arithmetic_left_shifter_if.sv
// Handshake bundle for the serial arithmetic left shifter: upstream operand port
// and downstream result port, each with valid/ready.
interface serial_arithmetic_left_shifter_if #(
  parameter int N  = 8,
  parameter int SW = 4
);
  logic          up_valid;
  logic          up_ready;
  logic [N-1:0]  up_data;
  logic [SW-1:0] up_shift;
  logic          down_valid;
  logic          down_ready;
  logic [N-1:0]  down_data;
  logic          down_overflow;

  modport master (
    output up_valid, up_data, up_shift, down_ready,
    input  up_ready, down_valid, down_data, down_overflow
  );

  modport slave (
    input  up_valid, up_data, up_shift, down_ready,
    output up_ready, down_valid, down_data, down_overflow
  );
endinterface

// File: rtl/serial_arithmetic_left_shifter.sv
// Iterative signed a * 2^S: one arithmetic left shift per clock with sticky overflow.
// Optional SERIAL_SHIFT_SATURATE_EN clamps overflowed results to the signed extreme.
module serial_arithmetic_left_shifter #(
  parameter int N  = 8,
  parameter int SW = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  serial_arithmetic_left_shifter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [SW-1:0] cnt_q,   cnt_d;
  logic          ovf_q,   ovf_d;
  logic [N-1:0]  data_q,  data_d;
  logic          dovf_q,  dovf_d;
`ifdef SERIAL_SHIFT_SATURATE_EN
  logic          sign_q,  sign_d;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    dovf_d  = dovf_q;
`ifdef SERIAL_SHIFT_SATURATE_EN
    sign_d  = sign_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.up_valid) begin
          shreg_d = bus.up_data;
          cnt_d   = bus.up_shift;
          ovf_d   = 1'b0;
`ifdef SERIAL_SHIFT_SATURATE_EN
          sign_d  = bus.up_data[N-1];
`endif
          if (bus.up_shift != '0) begin
            state_d = S_SHIFT;
          end else begin
            // Zero shift: the operand is the result and can never overflow.
            state_d = S_DONE;
            data_d  = bus.up_data;
            dovf_d  = 1'b0;
          end
        end
      end
      S_SHIFT: begin
        // A bit leaving the top that disagrees with the new sign bit means overflow.
        ovf_d   = ovf_q | (shreg_q[N-1] ^ shreg_q[N-2]);
        shreg_d = {shreg_q[N-2:0], 1'b0};
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == SW'(1)) begin
          state_d = S_DONE;
          dovf_d  = ovf_d;
`ifdef SERIAL_SHIFT_SATURATE_EN
          if (ovf_d) begin
            data_d = sign_q ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
          end else begin
            data_d = shreg_d;
          end
`else
          data_d  = shreg_d;
`endif
        end
      end
      S_DONE: begin
        if (bus.down_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
      dovf_q  <= 1'b0;
`ifdef SERIAL_SHIFT_SATURATE_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      dovf_q  <= dovf_d;
`ifdef SERIAL_SHIFT_SATURATE_EN
      sign_q  <= sign_d;
`endif
    end
  end

  assign bus.up_ready      = (state_q == S_IDLE);
  assign bus.down_valid    = (state_q == S_DONE);
  assign bus.down_data     = data_q;
  assign bus.down_overflow = dovf_q;

endmodule

// File: tb/tb_serial_arithmetic_left_shifter.sv
// Scoreboard bench for serial_arithmetic_left_shifter: driver queues expected results,
// a negedge monitor checks data, overflow and latency when down_valid rises.
module tb_serial_arithmetic_left_shifter;
  localparam int N  = 8;
  localparam int SW = 4;
`ifdef SERIAL_SHIFT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_arithmetic_left_shifter_if #(.N(N), .SW(SW)) bus ();

  serial_arithmetic_left_shifter #(.N(N), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       o;
    logic [7:0] lat;
  } exp_t;

  exp_t exp_q[$];
  time  acc_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;
  int acc_count = 0;
  bit dv_prev = 1'b0;
  bit hs_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each rising down_valid.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hs_prev) check("up_ready_after_handshake", {31'd0, bus.up_ready}, 32'd1);
      if (bus.down_valid && !dv_prev) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got data 0x%0h with nothing expected at %0t",
                   bus.down_data, $time);
        end else begin
          exp_t e;
          time  t;
          longint lat;
          e = exp_q.pop_front();
          t = acc_q.pop_front();
          lat = (longint'($time - t) - 5) / 10 + 1;
          check("down_data", {24'd0, bus.down_data}, {24'd0, e.d});
          check("down_overflow", {31'd0, bus.down_overflow}, {31'd0, e.o});
          check("latency", 32'(lat), {24'd0, e.lat});
          $display("result data=0x%0h ovf=%0b latency=%0d", bus.down_data, bus.down_overflow, lat);
        end
      end
      hs_prev = bus.down_valid && bus.down_ready;
      if (hs_prev) hs_count++;
      if (bus.up_valid && bus.up_ready) acc_count++;
    end else begin
      hs_prev = 1'b0;
    end
    dv_prev = bus.down_valid;
  end

  task automatic send(input logic [7:0] a, input logic [3:0] s,
                      input logic [7:0] ed, input logic eo, input bit push);
    int guard = 0;
    @(negedge clk);
    while (!bus.up_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: up_ready stayed 0 for a=0x%0h S=%0d", a, s);
      return;
    end
    if (push) exp_q.push_back('{d: ed, o: eo, lat: 8'(s) + 8'd1});
    bus.up_data  = a;
    bus.up_shift = s;
    bus.up_valid = 1'b1;
    @(posedge clk);
    if (push) acc_q.push_back($time);
    $display("issue a=0x%0h S=%0d expect data=0x%0h ovf=%0b", a, s, ed, eo);
    #1;
    bus.up_valid = 1'b0;
    bus.up_data  = 8'($urandom);
    bus.up_shift = 4'($urandom);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() != 0 || !bus.up_ready) && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 500) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
    end
  endtask

  logic [7:0] va   [10] = '{8'h05, 8'hF3, 8'hFF, 8'h50, 8'h90, 8'h81, 8'h00, 8'h01, 8'hFF, 8'h40};
  logic [3:0] vs   [10] = '{4'd3,  4'd2,  4'd7,  4'd2,  4'd1,  4'd0,  4'd15, 4'd15, 4'd8,  4'd1};
  logic [7:0] vwr  [10] = '{8'h28, 8'hCC, 8'h80, 8'h40, 8'h20, 8'h81, 8'h00, 8'h00, 8'h00, 8'h80};
  logic [7:0] vsat [10] = '{8'h28, 8'hCC, 8'h80, 8'h7F, 8'h80, 8'h81, 8'h00, 8'h7F, 8'h80, 8'h7F};
  logic       vov  [10] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};

  initial begin
    int hs_before;
    int acc_before;
    int guard;
    bus.up_valid   = 1'b0;
    bus.up_data    = '0;
    bus.up_shift   = '0;
    bus.down_ready = 1'b1;

    #7;
    check("reset_up_ready", {31'd0, bus.up_ready}, 32'd1);
    check("reset_down_valid", {31'd0, bus.down_valid}, 32'd0);
    check("reset_down_data", {24'd0, bus.down_data}, 32'd0);
    check("reset_down_overflow", {31'd0, bus.down_overflow}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      send(va[i], vs[i], (SAT && vov[i]) ? vsat[i] : vwr[i], vov[i], 1'b1);
    end
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    check("handshake_count", hs_count, 32'd10);
    check("accept_count", acc_count, 32'd10);

    // Backpressure: result must hold and no new operand may be taken.
    bus.down_ready = 1'b0;
    send(8'h05, 4'd3, 8'h28, 1'b0, 1'b1);
    guard = 0;
    while (!bus.down_valid && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("bp_reached_done", {31'd0, bus.down_valid}, 32'd1);
    hs_before  = hs_count;
    acc_before = acc_count;
    repeat (5) begin
      @(posedge clk);
      #1;
      bus.up_valid = ~bus.up_valid;
      bus.up_data  = 8'($urandom);
      bus.up_shift = 4'($urandom);
      #2;
      check("bp_data_stable", {24'd0, bus.down_data}, 32'h28);
      check("bp_up_ready_low", {31'd0, bus.up_ready}, 32'd0);
      check("bp_valid_held", {31'd0, bus.down_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    bus.up_valid   = 1'b0;
    bus.down_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid_dropped", {31'd0, bus.down_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_one_handshake", hs_count - hs_before, 32'd1);
    check("bp_no_accept", acc_count - acc_before, 32'd0);

    // Asynchronous reset mid-shift discards the operation.
    send(8'h05, 4'd6, 8'h40, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_up_ready", {31'd0, bus.up_ready}, 32'd1);
    check("arst_down_valid", {31'd0, bus.down_valid}, 32'd0);
    check("arst_down_data", {24'd0, bus.down_data}, 32'd0);
    check("arst_down_overflow", {31'd0, bus.down_overflow}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    hs_before = hs_count;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_up_ready", {31'd0, bus.up_ready}, 32'd1);
    check("post_rst_no_handshake", hs_count - hs_before, 32'd0);
    send(8'hF3, 4'd2, 8'hCC, 1'b0, 1'b1);
    wait_drain();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_arithmetic_left_shifter.md
Name: serial_arithmetic_left_shifter

Overview:
Iterative signed multiply-by-power-of-2. It computes a * 2^S by arithmetic left shift, one bit position per clock, with overflow detection. This is the counterpart of the arithmetic right shift / signed divide blocks in the combinational arithmetic set. Operands enter through a valid/ready upstream port and results leave through a valid/ready downstream port, so the block drops into handshake pipelines.

Parameters:
N, 8, operand and result width in bits, signed two's complement; N >= 2.
SW, 4, width of the shift-amount input; maximum shift is 2^SW - 1.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
up_valid  input  1  operand and shift amount are valid.
up_ready  output  1  block can accept a new operand.
up_data  input  N  signed operand a.
up_shift  input  SW  unsigned shift amount S.
down_valid  output  1  result is valid.
down_ready  input  1  consumer accepts the result.
down_data  output  N  signed result.
down_overflow  output  1  true result of a * 2^S is not representable in N bits.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, up_ready=1, down_valid=0, down_data=0, down_overflow=0, internal counter/shift register/overflow=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - up_ready=1.
  - On up_valid && up_ready: capture up_data into the shift register, up_shift into the counter, and sign = up_data[N-1]; clear overflow.
  - Next state is SHIFT if up_shift != 0, else DONE.
- SHIFT:
  - up_ready=0.
  - Each cycle: if reg[N-1] != reg[N-2], set overflow (sticky).
  - Then reg <= {reg[N-2:0], 1'b0} and counter decrements.
  - When counter == 1 at the cycle edge, go to DONE.
  - SHIFT lasts exactly S cycles; there is no early termination.
- DONE:
  - down_valid=1; down_data and down_overflow are stable while down_valid && !down_ready.
  - On down_ready, go to IDLE and drop down_valid in the same edge.
  - up_ready=0 in DONE; a new operand is accepted no earlier than the cycle after the result handshake.
- Latency from the accept edge to down_valid high:
  - S+1 edges for S >= 1 (S shift cycles plus the DONE transition).
  - 1 edge for S = 0; the result is a unchanged with overflow=0.
- Overflow rule: set if any bit shifted out of the top differs from the resulting sign bit. Examples for N=8:
  - a=-1, S=7 gives 0x80, no overflow.
  - a=-1, S=8 gives overflow.
- S >= N:
  - a=0 gives result 0, no overflow.
  - Any nonzero a gives overflow.
- Inputs up_data/up_shift are ignored outside the accept cycle; changing them during SHIFT has no effect.
- down_ready while not in DONE is ignored.
- rst_n asserted mid-SHIFT or mid-DONE: immediate return to reset values; the in-flight operation is discarded with no output handshake.
- down_data in IDLE/SHIFT is don't-care to consumers; the implementation holds the last result.

Optional Feature:
Macro SERIAL_SHIFT_SATURATE_EN.
- Defined: when overflow=1, down_data is saturated to the signed extreme matching the captured sign: 0x7F..F for non-negative a, 0x80..0 for negative a.
- Not defined: down_data is the wrapped low N bits of a * 2^S.
- down_overflow behaves identically in both builds.
- Latency and handshake are unchanged.

Test Plan:
- N=8, a=0x05, S=3, down_ready=1: down_valid exactly 4 cycles after accept, data=0x28, overflow=0; up_ready returns 1 the next cycle.
- a=0xF3 (-13), S=2: data=0xCC (-52), overflow=0. a=-1, S=7: data=0x80, overflow=0.
- a=0x50, S=2, overflow=1: data=0x7F if SERIAL_SHIFT_SATURATE_EN is defined, else 0x40. a=0x90, S=1, overflow=1: data=0x80 saturated, else 0x20.
- S=0 with a=0x81: data=0x81, overflow=0, latency 1. S=15 with a=0: data=0, overflow=0. S=15 with a=1: overflow=1.
- Backpressure: hold down_ready=0 for 5 cycles in DONE while toggling up_data/up_valid: data stays stable, up_ready=0, no second accept. Release down_ready: exactly one handshake.
- Assert rst_n=0 asynchronously mid-SHIFT (a=0x05, S=6, after 2 cycles): outputs go to reset values without a clock edge. After release: up_ready=1, no down_valid pulse, and a new operation completes correctly.
